// File: rtl/trig_dist_pkg.sv
// Shared types and WR-time helpers for the trigger distribution receive path.
// WR time is a {tai, cycles} pair; cycles wraps at the reference clock frequency.
package trig_dist_pkg;

  typedef struct packed {
    logic [39:0] tai;
    logic [27:0] cycles;
  } t_wr_time;

  typedef enum logic [1:0] {IDLE, WAIT, PULSE} t_pgen_state;

  // Adds cyc (< freq) to t, carrying one second when the cycles field wraps.
  function automatic t_wr_time wr_time_add(t_wr_time t, int cyc, int freq);
    t_wr_time    r;
    logic [28:0] sum;
    sum = {1'b0, t.cycles} + 29'(cyc);
    if (sum >= 29'(freq)) begin
      r.cycles = 28'(sum - 29'(freq));
      r.tai    = t.tai + 40'd1;
    end else begin
      r.cycles = sum[27:0];
      r.tai    = t.tai;
    end
    return r;
  endfunction

  // Packed layout puts tai above cycles, so a plain compare orders WR times.
  function automatic logic wr_time_ge(t_wr_time a, t_wr_time b);
    return a >= b;
  endfunction

endpackage

// File: rtl/trig_ts_fifo.sv
// Synchronous FIFO of WR timestamps with first-word-fall-through head,
// occupancy count and a synchronous flush.
module trig_ts_fifo
  import trig_dist_pkg::*;
#(
  parameter int g_depth = 8
) (
  input  logic                       clk_ref_i,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       push,
  input  t_wr_time                   din,
  input  logic                       pop,
  output t_wr_time                   head,
  output logic                       empty,
  output logic [$clog2(g_depth):0]   count
);

  localparam int AW = $clog2(g_depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(g_depth);

  t_wr_time        mem [g_depth];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && (count_reg != DEPTH_C);

  always_ff @(posedge clk_ref_i) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/trig_delayed_pulse_gen.sv
// Replays received WR triggers after a fixed latency: deadlines are queued and a
// fixed-width pulse is emitted when local WR time reaches each one.
module trig_delayed_pulse_gen
  import trig_dist_pkg::*;
#(
  parameter int g_clk_freq    = 125_000_000,
  parameter int g_latency_cyc = 2500,
  parameter int g_fifo_depth  = 8,
  parameter int g_pulse_width = 125
) (
  input  logic        clk_ref_i,
  input  logic        rst_i,
  input  logic        tm_time_valid_i,
  input  logic [39:0] tm_tai_i,
  input  logic [27:0] tm_cycles_i,
  input  logic        trig_valid_i,
  input  logic [39:0] trig_tai_i,
  input  logic [27:0] trig_cycles_i,
  output logic        trig_ready_o,
  output logic        pulse_o,
  output logic [15:0] cnt_missed_o,
  output logic [15:0] cnt_overflow_o
);

  localparam int CW   = $clog2(g_fifo_depth) + 1;
  localparam int PW_W = $clog2(g_pulse_width + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(g_fifo_depth);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(g_pulse_width - 1);

  if (g_latency_cyc >= g_clk_freq || g_fifo_depth < 2 ||
      (g_fifo_depth & (g_fifo_depth - 1)) != 0 || g_pulse_width < 1) begin : g_param_check
    $error("trig_delayed_pulse_gen: illegal parameter combination");
  end

  t_wr_time        now_time;
  t_wr_time        trig_time;
  t_wr_time        add_time_reg;
  t_wr_time        dl_reg;
  t_wr_time        fifo_head;
  logic            add_valid_reg;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   occupancy;
  logic            accept;
  logic            drop_ovf;
  logic            push;
  logic            pop;
  logic            miss_evt;
  logic            dl_reached;
  logic            dl_late;
  logic [PW_W-1:0] width_cnt_reg;
  t_pgen_state     state_reg;
  t_pgen_state     state_next;
  logic [1:0]      cnt_inc;
  logic [1:0][15:0] cnt_all;

  assign now_time  = {tm_tai_i, tm_cycles_i};
  assign trig_time = {trig_tai_i, trig_cycles_i};

  // The in-flight adder entry reserves a slot so a push never meets a full queue.
  assign occupancy    = fifo_count + {{(CW-1){1'b0}}, add_valid_reg};
  assign trig_ready_o = (occupancy != DEPTH_C);
  assign accept       = tm_time_valid_i && trig_valid_i && trig_ready_o;
  assign drop_ovf     = tm_time_valid_i && trig_valid_i && !trig_ready_o;
  assign push         = tm_time_valid_i && add_valid_reg;

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || !tm_time_valid_i) add_valid_reg <= 1'b0;
    else                           add_valid_reg <= accept;
  end

  always_ff @(posedge clk_ref_i) begin
    if (accept) add_time_reg <= wr_time_add(trig_time, g_latency_cyc, g_clk_freq);
  end

  trig_ts_fifo #(
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk_ref_i (clk_ref_i),
    .rst_i     (rst_i),
    .flush     (!tm_time_valid_i),
    .push      (push),
    .din       (add_time_reg),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign dl_reached = (now_time == dl_reg);
  assign dl_late    = !wr_time_ge(dl_reg, now_time);

  always_ff @(posedge clk_ref_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!tm_time_valid_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (!fifo_empty) state_next = WAIT;
        WAIT:    if (dl_reached) state_next = PULSE;
                 else if (dl_late) state_next = IDLE;
        PULSE:   if (width_cnt_reg == PW_LAST) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pop      = tm_time_valid_i && (state_reg == IDLE) && !fifo_empty;
    miss_evt = tm_time_valid_i && (state_reg == WAIT) && !dl_reached && dl_late;
    pulse_o  = (state_reg == PULSE);
  end

  always_ff @(posedge clk_ref_i) begin
    if (pop) dl_reg <= fifo_head;
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || state_reg != PULSE) width_cnt_reg <= '0;
    else                             width_cnt_reg <= width_cnt_reg + 1'b1;
  end

  // Index 0 counts missed deadlines, index 1 counts overflow drops.
  assign cnt_inc = {drop_ovf, miss_evt};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sat_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge clk_ref_i) begin
      if (rst_i)                                cnt_reg <= '0;
      else if (cnt_inc[gi] && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
    end
    assign cnt_all[gi] = cnt_reg;
  end

  assign cnt_missed_o   = cnt_all[0];
  assign cnt_overflow_o = cnt_all[1];

endmodule

// File: tb/tb_trig_delayed_pulse_gen.sv
// Bench for trig_delayed_pulse_gen: WR time is kept as an absolute cycle count and
// expected pulse instants are simply trigger time + latency in that count.
module tb_trig_delayed_pulse_gen;

  localparam longint FREQ = 125_000_000;
  localparam longint LAT  = 2500;
  localparam longint PW   = 125;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tm_time_valid;
  logic [39:0] tm_tai;
  logic [27:0] tm_cycles;
  logic        trig_valid;
  logic [39:0] trig_tai;
  logic [27:0] trig_cycles;
  logic        trig_ready;
  logic        pulse;
  logic [15:0] cnt_missed;
  logic [15:0] cnt_overflow;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint now_abs;
  longint exp_missed;
  longint exp_ovf;
  longint exp_q[$];
  longint rise_q[$];
  longint width_q[$];
  longint edge_abs;
  logic   pulse_prev = 1'b0;
  int     wcnt = 0;

  always #4 clk = ~clk;

  trig_delayed_pulse_gen #(
    .g_clk_freq    (125_000_000),
    .g_latency_cyc (2500),
    .g_fifo_depth  (8),
    .g_pulse_width (125)
  ) dut (
    .clk_ref_i       (clk),
    .rst_i           (rst_i),
    .tm_time_valid_i (tm_time_valid),
    .tm_tai_i        (tm_tai),
    .tm_cycles_i     (tm_cycles),
    .trig_valid_i    (trig_valid),
    .trig_tai_i      (trig_tai),
    .trig_cycles_i   (trig_cycles),
    .trig_ready_o    (trig_ready),
    .pulse_o         (pulse),
    .cnt_missed_o    (cnt_missed),
    .cnt_overflow_o  (cnt_overflow)
  );

  // Local time seen by the DUT at each active edge, as an absolute cycle count.
  always @(posedge clk) edge_abs <= longint'(tm_tai) * FREQ + longint'(tm_cycles);

  always @(negedge clk) begin
    pulse_prev <= pulse;
    if (pulse && !pulse_prev) begin
      rise_q.push_back(edge_abs);
      wcnt <= 1;
    end else if (pulse) begin
      wcnt <= wcnt + 1;
    end else if (pulse_prev) begin
      width_q.push_back(longint'(wcnt));
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_tm();
    tm_tai    = 40'(now_abs / FREQ);
    tm_cycles = 28'(now_abs % FREQ);
  endtask

  task automatic set_time(input longint t);
    now_abs = t;
    drive_tm();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      now_abs++;
      drive_tm();
    end
  endtask

  task automatic set_trig(input longint t);
    trig_tai    = 40'(t / FREQ);
    trig_cycles = 28'(t % FREQ);
  endtask

  task automatic send_trig(input longint t);
    trig_valid = 1'b1;
    set_trig(t);
    step(1);
    trig_valid = 1'b0;
  endtask

  // Wait (bounded) for the expected pulses, then compare instants and widths.
  task automatic run_pulses(input int budget);
    int b = 0;
    while (width_q.size() < exp_q.size() && b < budget) begin
      step(1);
      b++;
    end
    step(3);
    check_val("pulse_count", rise_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rise_q.size() > 0)
      check_val("pulse_at", rise_q.pop_front(), exp_q.pop_front());
    while (width_q.size() > 0)
      check_val("pulse_width", width_q.pop_front(), PW);
    exp_q.delete();
    rise_q.delete();
  endtask

  task automatic one_trig(input longint t);
    set_time(t);
    send_trig(t);
    exp_q.push_back(t + LAT);
    step(4);
    set_time(t + LAT - 10);
    run_pulses(300);
  endtask

  initial begin
    longint t;
    longint b0;
    int     b;
    rst_i = 1'b1;
    tm_time_valid = 1'b1;
    trig_valid = 1'b0;
    set_trig(0);
    exp_missed = 0;
    exp_ovf = 0;
    set_time(5 * FREQ);
    step(3);
    check_val("rst_pulse", pulse, 0);
    check_val("rst_ready", trig_ready, 1);
    check_val("rst_missed", cnt_missed, 0);
    check_val("rst_overflow", cnt_overflow, 0);
    rst_i = 1'b0;
    step(2);

    // Single trigger, then one whose deadline crosses a second boundary.
    one_trig(5 * FREQ + 1000);
    one_trig(7 * FREQ + 124_999_000);

    // Deadline already in the past when evaluated.
    set_time(4 * FREQ);
    send_trig(3 * FREQ);
    exp_missed++;
    step(10);
    check_val("late_missed", cnt_missed, exp_missed);
    run_pulses(0);

    // Overflow: a pending deadline blocks draining while 10 triggers arrive.
    b0 = 20 * FREQ + 5000;
    set_time(b0);
    send_trig(b0);
    exp_q.push_back(b0 + LAT);
    step(4);
    for (int i = 0; i < 10; i++) begin
      t = b0 + 200 * (i + 1);
      trig_valid = 1'b1;
      set_trig(t);
      check_val("burst_ready", trig_ready, (i < 8) ? 1 : 0);
      if (i < 8) exp_q.push_back(t + LAT);
      else       exp_ovf++;
      step(1);
    end
    trig_valid = 1'b0;
    step(1);
    check_val("burst_overflow", cnt_overflow, exp_ovf);
    set_time(b0 + LAT - 10);
    run_pulses(2500);
    check_val("burst_ready_after", trig_ready, 1);

    // Time loss mid-pulse flushes everything; triggers while invalid are ignored.
    t = 30 * FREQ + 100;
    set_time(t);
    for (int i = 0; i < 3; i++) begin
      trig_valid = 1'b1;
      set_trig(t + 200 * i);
      step(1);
    end
    trig_valid = 1'b0;
    step(4);
    set_time(t + LAT - 10);
    b = 0;
    while (!pulse && b < 40) begin
      step(1);
      b++;
    end
    step(5);
    check_val("tl_pulse_high", pulse, 1);
    tm_time_valid = 1'b0;
    step(1);
    check_val("tl_pulse_low", pulse, 0);
    send_trig(now_abs - LAT + 100);
    check_val("tl_ready", trig_ready, 1);
    check_val("tl_overflow", cnt_overflow, exp_ovf);
    tm_time_valid = 1'b1;
    step(600);
    width_q.delete();
    exp_q.push_back(t + LAT);
    run_pulses(0);
    check_val("tl_missed", cnt_missed, exp_missed);

    // Reset while waiting on a deadline with another one queued.
    t = 40 * FREQ + 7000;
    set_time(t);
    send_trig(t);
    send_trig(t + 200);
    step(5);
    rst_i = 1'b1;
    step(1);
    exp_missed = 0;
    exp_ovf = 0;
    check_val("rw_pulse", pulse, 0);
    check_val("rw_ready", trig_ready, 1);
    check_val("rw_missed", cnt_missed, 0);
    check_val("rw_overflow", cnt_overflow, 0);
    rst_i = 1'b0;
    set_time(t + LAT - 10);
    step(500);
    run_pulses(0);

    // Randomized triggers, some near the second wrap, some already late.
    for (int k = 0; k < 8; k++) begin
      longint tai;
      longint cyc;
      tai = longint'($urandom_range(50, 1000));
      if ($urandom_range(0, 1) == 0) cyc = longint'($urandom_range(124_997_000, 124_999_999));
      else                           cyc = longint'($urandom_range(0, 124_999_999));
      t = tai * FREQ + cyc;
      if ($urandom_range(0, 3) == 0) begin
        set_time(t + LAT + longint'($urandom_range(1, 100)));
        send_trig(t);
        exp_missed++;
        step(6);
        check_val("rand_missed", cnt_missed, exp_missed);
        run_pulses(0);
      end else begin
        one_trig(t);
      end
    end

    check_val("final_missed", cnt_missed, exp_missed);
    check_val("final_overflow", cnt_overflow, exp_ovf);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
